// File: rtl/alu_control_transfer.sv
// Branch/jump resolution unit with a one-deep registered result stage.
// Ports: clock/reset_n, flush, in_valid/in_ready request handshake,
//   op/pc/rs1_value/rs2_value/immediate request fields,
//   out_valid/out_ready result handshake, next_pc/rd_value/rd_write/taken/
//   misaligned/illegal result fields, taken_count saturating counter.
module alu_control_transfer #(
    parameter int XLEN       = 32,
    parameter int COMPRESSED = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_value,
    input  logic [XLEN-1:0]  rs2_value,
    input  logic [XLEN-1:0]  immediate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  next_pc,
    output logic [XLEN-1:0]  rd_value,
    output logic             rd_write,
    output logic             taken,
    output logic             misaligned,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [3:0] OP_JAL  = 4'd0;
    localparam logic [3:0] OP_JALR = 4'd1;
    localparam logic [3:0] OP_BEQ  = 4'd2;
    localparam logic [3:0] OP_BNE  = 4'd3;
    localparam logic [3:0] OP_BLT  = 4'd4;
    localparam logic [3:0] OP_BGE  = 4'd5;
    localparam logic [3:0] OP_BLTU = 4'd6;
    localparam logic [3:0] OP_BGEU = 4'd7;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  npc_q, npc_d;
    logic [XLEN-1:0]  rdv_q, rdv_d;
    logic             rdw_q, rdw_d;
    logic             tkn_q, tkn_d;
    logic             mis_q, mis_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  target;
    logic             is_jump;
    logic             is_ill;
    logic             cond;
    logic             take;
    logic             mis;

    assign in_ready = (!valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        pc4      = pc + FOUR;
        jalr_sum = rs1_value + immediate;
        is_jump  = 1'b0;
        is_ill   = 1'b0;
        cond     = 1'b0;
        target   = pc + immediate;
        case (op)
            OP_JAL:  is_jump = 1'b1;
            OP_JALR: begin
                is_jump = 1'b1;
                target  = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_BEQ:  cond = (rs1_value == rs2_value);
            OP_BNE:  cond = (rs1_value != rs2_value);
            OP_BLT:  cond = ($signed(rs1_value) <  $signed(rs2_value));
            OP_BGE:  cond = ($signed(rs1_value) >= $signed(rs2_value));
            OP_BLTU: cond = (rs1_value <  rs2_value);
            OP_BGEU: cond = (rs1_value >= rs2_value);
            default: is_ill = 1'b1;
        endcase
        take = is_jump || cond;
        // Alignment only matters once fetch would actually be redirected.
        if (COMPRESSED != 0) begin
            mis = take && target[0];
        end else begin
            mis = take && (target[1:0] != 2'b00);
        end
    end

    always_comb begin
        valid_d = valid_q;
        npc_d   = npc_q;
        rdv_d   = rdv_q;
        rdw_d   = rdw_q;
        tkn_d   = tkn_q;
        mis_d   = mis_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            npc_d = take ? target : pc4;
            rdv_d = is_jump ? pc4 : '0;
            rdw_d = is_jump && !mis;
            tkn_d = take;
            mis_d = mis;
            ill_d = is_ill;
            // Counted at acceptance so a later stall or flush cannot lose it.
            if (take && !mis && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            npc_q   <= '0;
            rdv_q   <= '0;
            rdw_q   <= 1'b0;
            tkn_q   <= 1'b0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            npc_q   <= npc_d;
            rdv_q   <= rdv_d;
            rdw_q   <= rdw_d;
            tkn_q   <= tkn_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign next_pc     = npc_q;
    assign rd_value    = rdv_q;
    assign rd_write    = rdw_q;
    assign taken       = tkn_q;
    assign misaligned  = mis_q;
    assign illegal     = ill_q;
    assign taken_count = cnt_q;

endmodule

// File: doc/alu_control_transfer.md
ALU_CONTROL_TRANSFER -- requirements
Module: alu_control_transfer

Interface
REQ-001 Parameter XLEN, default 32: datapath width of pc, operands, immediate and results.
REQ-002 Parameter COMPRESSED, default 0: 0 = 4-byte target alignment required, 1 = 2-byte.
REQ-003 Parameter CNT_W, default 16: width of the taken-transfer counter.
REQ-004 clock  input  1  rising-edge clock; the block's only clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous; discards the held result.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block accepts a request this cycle.
REQ-009 op  input  4  0 JAL, 1 JALR, 2 BEQ, 3 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU, 8-15 illegal.
REQ-010 pc  input  XLEN  address of the instruction.
REQ-011 rs1_value, rs2_value  input  XLEN each  source operands.
REQ-012 immediate  input  XLEN  sign-extended J/I/B immediate.
REQ-013 out_valid  output  1  result register holds a valid result.
REQ-014 out_ready  input  1  consumer takes the result this cycle.
REQ-015 next_pc  output  XLEN  next fetch address, or faulting target when misaligned.
REQ-016 rd_value  output  XLEN  link value.
REQ-017 rd_write  output  1  rd_value is to be written.
REQ-018 taken  output  1  control transfer redirects fetch.
REQ-019 misaligned  output  1  instruction-address-misaligned exception.
REQ-020 illegal  output  1  op is in the range 8-15.
REQ-021 taken_count  output  CNT_W  saturating count of taken, non-faulting transfers.

Function
REQ-022 Handshake: a request is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-023 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-024 Latency: results appear registered one cycle after acceptance; out_valid rises on that same edge.
REQ-025 While out_valid=1 and out_ready=0, every output SHALL hold stable.
REQ-026 When out_ready=1, out_valid=1 and no new acceptance occurs, out_valid SHALL clear.
REQ-027 Back-to-back: accept on every edge with out_ready=1 gives one result per cycle with no bubbles.
REQ-028 Target computation, all XLEN-bit modulo 2^XLEN (wrap-around permitted, no flag):
  - JAL and branches: target = pc + immediate.
  - JALR: target = (rs1_value + immediate) with bit 0 cleared.
REQ-029 Branch conditions:
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
  - BEQ/BNE: equality.
REQ-030 JAL and JALR are always taken, with rd_write=1 and rd_value=pc+4 (modulo 2^XLEN).
REQ-031 Branches have rd_write=0 and rd_value=0.
  - Taken branch: next_pc = target.
  - Not-taken branch: next_pc = pc+4, taken=0.
REQ-032 Misalignment check on taken transfers only:
  - COMPRESSED=0: check target[1:0]!=0.
  - COMPRESSED=1: check target[0]!=0.
  - On fault: misaligned=1, taken=1, rd_write=0, next_pc=target.
REQ-033 A not-taken branch SHALL never raise misaligned.
REQ-034 Illegal op: illegal=1, taken=0, rd_write=0, misaligned=0, next_pc=pc+4, rd_value=0.
REQ-035 taken_count increments by 1 on each accepted request that is taken with misaligned=0.
  - Saturates at 2^CNT_W-1.
  - Increments at acceptance, independent of out_ready and of flush.
REQ-036 flush=1 clears out_valid on the next edge and blocks acceptance in that cycle.
  - Data registers may retain stale values.
  - taken_count is unaffected.

Reset
REQ-037 reset_n=0 SHALL immediately and asynchronously force:
  - out_valid, taken, rd_write, misaligned, illegal to 0.
  - next_pc, rd_value, taken_count to 0.
REQ-038 Reset asserted while a result is held or a request is presented SHALL discard both; nothing is counted.
REQ-039 After reset_n deasserts, in_ready=1 on the first clock edge, provided flush=0.

Verification
REQ-040 The bench SHALL cover JAL: pc=0x100, imm=0x20, out_ready=1 -> one cycle later out_valid=1, next_pc=0x120, rd_value=0x104, rd_write=1, taken=1, taken_count=1.
REQ-041 The bench SHALL cover JALR misaligned: COMPRESSED=0, rs1=0x203, imm=0 -> target 0x202, misaligned=1, rd_write=0, next_pc=0x202, taken_count unchanged.
REQ-042 The bench SHALL cover BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1, pc=0x40, imm=8.
  - BLT: taken, next_pc=0x48.
  - BLTU: not taken, next_pc=0x44.
REQ-043 The bench SHALL cover backpressure: out_ready=0 for 3 cycles with a second request pending -> in_ready=0, first result stable; out_ready=1 -> second result appears the next cycle.
REQ-044 The bench SHALL cover flush and reset: flush with out_valid=1 -> out_valid=0 next edge; reset_n pulse mid-operation -> all outputs 0 asynchronously, taken_count=0.
REQ-045 The bench SHALL cover counter saturation and illegal op:
  - CNT_W=2, five taken JALs -> taken_count=3.
  - op=9 -> illegal=1, next_pc=pc+4.
